prog_loader_ctrl: RTL and testbench

//   Boot/run controller for the 8-bit accumulator CPU and its 16x8 memory.

---
 rtl/prog_loader_if.sv | 43 ++++
 rtl/prog_loader_ctrl.sv | 108 ++++++++++
 tb/tb_prog_loader_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: bundle of every non-clock signal of the boot/run controller.
//   Byte stream : start, byte_valid, byte_data -> byte_ready
//   CPU side    : cpu_read, cpu_write, cpu_address, cpu_memoryIn -> cpu_clr
//   Memory side : mem_read, mem_write, mem_address, mem_memoryIn
//   Status      : busy, done, load_count
// slave  = the controller, master = whatever drives the stream and the CPU strobes.
interface prog_loader_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          start;
  logic          byte_valid;
  logic [DW-1:0] byte_data;
  logic          byte_ready;
  logic          cpu_read;
  logic          cpu_write;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_memoryIn;
  logic          cpu_clr;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_memoryIn;
  logic          busy;
  logic          done;
  logic [AW:0]   load_count;

  modport slave (
    input  start, byte_valid, byte_data,
    input  cpu_read, cpu_write, cpu_address, cpu_memoryIn,
    output byte_ready, cpu_clr,
    output mem_read, mem_write, mem_address, mem_memoryIn,
    output busy, done, load_count
  );

  modport master (
    output start, byte_valid, byte_data,
    output cpu_read, cpu_write, cpu_address, cpu_memoryIn,
    input  byte_ready, cpu_clr,
    input  mem_read, mem_write, mem_address, mem_memoryIn,
    input  busy, done, load_count
  );
endinterface

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: boot/run controller for the accumulator CPU and its memory.
//   Streams a full program image (2**AW bytes) into memory while the CPU is held
//   in clear, then lets the CPU run for RUN_CYCLES cycles (0 = forever) and halts.
//   The controller owns the memory port: the loader drives it in LOAD, the CPU
//   in RUN, and it is idle otherwise.
// Ports
//   clk  : clock, all state on rising edge
//   clr  : synchronous active-high reset -> IDLE
//   bus  : prog_loader_if.slave (byte stream, CPU strobes, memory port, status)
module prog_loader_ctrl #(
  parameter int AW         = 4,
  parameter int DW         = 8,
  parameter int RUN_CYCLES = 64,
  parameter int CW         = 16
) (
  input logic           clk,
  input logic           clr,
  prog_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  localparam logic [AW-1:0] PTR_LAST = '1;
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES == 0 ? 0 : RUN_CYCLES - 1);

  state_t        state, nextState;
  logic [AW-1:0] ptr;
  logic [AW:0]   loadCount;
  logic [CW-1:0] runCnt;
  logic          xfer, lastXfer, runExpired;

  // byte_ready is exactly "in LOAD", so a transfer is just valid while loading.
  assign xfer       = (state == LOAD) && bus.byte_valid;
  assign lastXfer   = xfer && (ptr == PTR_LAST);
  assign runExpired = (RUN_CYCLES != 0) && (runCnt == RUN_LAST);

  // State register plus load/run counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      ptr       <= '0;
      loadCount <= '0;
      runCnt    <= '0;
    end else begin
      state <= nextState;
      // Any entry into LOAD (from IDLE, RUN abort or HALT) restarts the image.
      if (nextState == LOAD && state != LOAD) begin
        ptr       <= '0;
        loadCount <= '0;
      end else if (xfer) begin
        ptr       <= ptr + AW'(1);
        loadCount <= loadCount + (AW+1)'(1);
      end
      if (lastXfer)
        runCnt <= '0;
      else if (state == RUN)
        runCnt <= runCnt + CW'(1);
    end
  end

  // Next state. In RUN a start pulse beats the halt condition.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (bus.start) nextState = LOAD;
      LOAD: if (lastXfer) nextState = RUN;
      RUN: begin
        if (bus.start)       nextState = LOAD;
        else if (runExpired) nextState = HALT;
      end
      HALT: if (bus.start) nextState = LOAD;
      default: nextState = IDLE;
    endcase
  end

  // Outputs. Memory port is muxed combinationally so a write lands the same
  // cycle the byte (or CPU strobe) is presented.
  always_comb begin
    bus.byte_ready   = 1'b0;
    bus.cpu_clr      = 1'b1;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_address  = '0;
    bus.mem_memoryIn = '0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    unique case (state)
      LOAD: begin
        bus.byte_ready   = 1'b1;
        bus.mem_write    = bus.byte_valid;
        bus.mem_address  = ptr;
        bus.mem_memoryIn = bus.byte_data;
        bus.busy         = 1'b1;
      end
      RUN: begin
        bus.cpu_clr      = 1'b0;
        bus.mem_read     = bus.cpu_read;
        bus.mem_write    = bus.cpu_write;
        bus.mem_address  = bus.cpu_address;
        bus.mem_memoryIn = bus.cpu_memoryIn;
        bus.busy         = 1'b1;
      end
      HALT: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.load_count = loadCount;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
module tb_prog_loader_ctrl;
  localparam int AW = 4, DW = 8, RUN_CYCLES = 64, CW = 16, DEPTH = 16;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  prog_loader_if #(.AW(AW), .DW(DW)) bus();

  prog_loader_ctrl #(.AW(AW), .DW(DW), .RUN_CYCLES(RUN_CYCLES), .CW(CW)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  // Bench-side memory driven by the controller's memory port.
  logic [7:0] tbMem [DEPTH];
  int nWrites;
  always @(posedge clk) begin
    if (bus.mem_write) begin
      tbMem[bus.mem_address] <= bus.mem_memoryIn;
      nWrites <= nWrites + 1;
    end
  end

  int nChecks = 0, nPass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit st, input bit bv, input logic [7:0] bd,
                       input bit rd, input bit wr, input logic [3:0] ad, input logic [7:0] di);
    bus.start = st; bus.byte_valid = bv; bus.byte_data = bd;
    bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_address = ad; bus.cpu_memoryIn = di;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic doClr();
    clr = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    tick(); tick();
    clr = 1'b0;
  endtask

  task automatic pulseStart();
    drive(1, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    tick();
    drive(0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
  endtask

  typedef struct {
    logic       st, bv;
    logic [7:0] bd;
    logic       wr;
    logic [3:0] ad;
    logic [7:0] di;
    logic       eRdy, eClr, eWr;
    logic [3:0] eAd;
    logic [7:0] eDi;
    logic       eBusy, eDone;
    logic [4:0] eLc;
  } vec_t;

  vec_t vecs [6];

  // reference model state (random phase)
  bit mLoad, mRun, mDone;
  int mCnt, mRunCnt;
  logic [7:0] modelMem [DEPTH];

  initial begin
    int low;
    // st bv bd    wr ad   di    | rdy clr wr ad   di    busy done lc
    vecs[0] = '{0, 1, 8'h33, 1, 4'd3, 8'h5A, 0, 1, 0, 4'd0, 8'h00, 0, 0, 5'd0}; // idle: nothing passes
    vecs[1] = '{1, 0, 8'h00, 0, 4'd0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0, 0, 5'd0}; // start
    vecs[2] = '{0, 1, 8'h10, 1, 4'd9, 8'hEE, 1, 1, 1, 4'd0, 8'h10, 1, 0, 5'd0}; // first byte, cpu blocked
    vecs[3] = '{0, 0, 8'h77, 0, 4'd0, 8'h00, 1, 1, 0, 4'd1, 8'h77, 1, 0, 5'd1}; // gap
    vecs[4] = '{1, 1, 8'h11, 0, 4'd0, 8'h00, 1, 1, 1, 4'd1, 8'h11, 1, 0, 5'd1}; // start ignored
    vecs[5] = '{0, 0, 8'h00, 0, 4'd0, 8'h00, 1, 1, 0, 4'd2, 8'h00, 1, 0, 5'd2};

    nWrites = 0;
    clr = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    tick();
    doClr();

    // reset state
    #2;
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_cpu_clr", bus.cpu_clr, 1);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_memoryIn", bus.mem_memoryIn, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_load_count", bus.load_count, 0);
    tick();

    // table vectors
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].st, vecs[i].bv, vecs[i].bd, 0, vecs[i].wr, vecs[i].ad, vecs[i].di);
      #2;
      chk($sformatf("vec%0d_byte_ready", i), bus.byte_ready, vecs[i].eRdy);
      chk($sformatf("vec%0d_cpu_clr", i), bus.cpu_clr, vecs[i].eClr);
      chk($sformatf("vec%0d_mem_write", i), bus.mem_write, vecs[i].eWr);
      chk($sformatf("vec%0d_mem_address", i), bus.mem_address, vecs[i].eAd);
      chk($sformatf("vec%0d_mem_memoryIn", i), bus.mem_memoryIn, vecs[i].eDi);
      chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].eBusy);
      chk($sformatf("vec%0d_done", i), bus.done, vecs[i].eDone);
      chk($sformatf("vec%0d_load_count", i), bus.load_count, vecs[i].eLc);
      tick();
    end

    // back-to-back full load, bounded run, halt
    doClr();
    pulseStart();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(8'h10 + i), 0, 0, 4'h0, 8'h00);
      #2;
      chk($sformatf("bb_wr%0d", i), bus.mem_write, 1);
      chk($sformatf("bb_addr%0d", i), bus.mem_address, i);
      chk($sformatf("bb_clr%0d", i), bus.cpu_clr, 1);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    #2;
    chk("bb_cpu_clr_fall", bus.cpu_clr, 0);
    chk("bb_load_count", bus.load_count, 16);
    chk("bb_byte_ready_run", bus.byte_ready, 0);
    low = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 3) drive(0, 1, 8'hCC, 0, 1, 4'd5, 8'hA5);
      else drive(0, 1, 8'hCC, 0, 0, 4'd0, 8'h00);
      #2;
      if (bus.cpu_clr) break;
      if (c == 3) begin
        chk("run_pass_addr", bus.mem_address, 5);
        chk("run_pass_write", bus.mem_write, 1);
        chk("run_pass_data", bus.mem_memoryIn, 8'hA5);
      end
      low++;
      tick();
    end
    chk("run_length", low, RUN_CYCLES);
    drive(0, 0, 8'h00, 0, 1, 4'd5, 8'h3C);
    #1;
    chk("halt_done", bus.done, 1);
    chk("halt_cpu_clr", bus.cpu_clr, 1);
    chk("halt_mem_write", bus.mem_write, 0);
    chk("halt_busy", bus.busy, 0);
    chk("halt_load_count", bus.load_count, 16);
    tick();
    chk("mem0", tbMem[0], 8'h10);
    chk("mem5", tbMem[5], 8'hA5);
    chk("mem15", tbMem[15], 8'h1F);

    // load with 3-cycle gaps, then abort the run at cycle 10
    doClr();
    nWrites = 0;
    pulseStart();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(8'h40 + i), 0, 0, 4'h0, 8'h00);
      #2;
      chk($sformatf("gap_addr%0d", i), bus.mem_address, i);
      tick();
      if (i < 15) begin
        for (int g = 0; g < 3; g++) begin
          drive(0, 0, 8'hFF, 0, 0, 4'h0, 8'h00);
          #2;
          chk("gap_no_write", bus.mem_write, 0);
          chk("gap_ptr_hold", bus.mem_address, i + 1);
          tick();
        end
      end
    end
    drive(0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    chk("gap_write_count", nWrites, 16);
    chk("gap_mem7", tbMem[7], 8'h47);
    for (int c = 0; c < 10; c++) tick();
    pulseStart();
    #2;
    chk("abort_cpu_clr", bus.cpu_clr, 1);
    chk("abort_byte_ready", bus.byte_ready, 1);
    chk("abort_load_count", bus.load_count, 0);
    chk("abort_done", bus.done, 0);

    // clr after 7 bytes, then a full reload
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 8'(8'h60 + i), 0, 0, 4'h0, 8'h00);
      tick();
    end
    doClr();
    #2;
    chk("clr7_load_count", bus.load_count, 0);
    chk("clr7_byte_ready", bus.byte_ready, 0);
    chk("clr7_busy", bus.busy, 0);
    chk("clr7_partial6", tbMem[6], 8'h66);
    chk("clr7_old7", tbMem[7], 8'h47);
    pulseStart();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(8'h80 + i), 0, 0, 4'h0, 8'h00);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    #2;
    chk("reload_load_count", bus.load_count, 16);
    chk("reload_cpu_clr", bus.cpu_clr, 0);
    for (int a = 0; a < DEPTH; a++) chk($sformatf("reload_mem%0d", a), tbMem[a], 8'(8'h80 + a));

    // randomized traffic against the reference model
    doClr();
    mLoad = 0; mRun = 0; mDone = 0; mCnt = 0; mRunCnt = 0;
    for (int a = 0; a < DEPTH; a++) modelMem[a] = tbMem[a];
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit st, bv, rd, wr, c;
      logic [7:0] bd, di;
      logic [3:0] ad;
      bit eWr, eRd;
      logic [3:0] eAd;
      logic [7:0] eDi;
      st = ($urandom_range(0, 99) == 0);
      bv = ($urandom_range(0, 9) < 7);
      bd = 8'($urandom);
      rd = 1'($urandom);
      wr = 1'($urandom);
      ad = 4'($urandom);
      di = 8'($urandom);
      c  = ($urandom_range(0, 299) == 0);
      clr = c;
      drive(st, bv, bd, rd, wr, ad, di);
      eWr = mLoad ? bv : (mRun ? wr : 1'b0);
      eRd = mRun ? rd : 1'b0;
      eAd = mLoad ? 4'(mCnt) : (mRun ? ad : 4'h0);
      eDi = mLoad ? bd : (mRun ? di : 8'h00);
      #2;
      chk("rnd_byte_ready", bus.byte_ready, mLoad);
      chk("rnd_cpu_clr", bus.cpu_clr, !mRun);
      chk("rnd_busy", bus.busy, mLoad | mRun);
      chk("rnd_done", bus.done, mDone);
      chk("rnd_load_count", bus.load_count, mCnt);
      chk("rnd_mem_write", bus.mem_write, eWr);
      chk("rnd_mem_read", bus.mem_read, eRd);
      chk("rnd_mem_address", bus.mem_address, eAd);
      chk("rnd_mem_memoryIn", bus.mem_memoryIn, eDi);
      if (eWr) modelMem[eAd] = eDi;
      if (c) begin
        mLoad = 0; mRun = 0; mDone = 0; mCnt = 0; mRunCnt = 0;
      end else if (mLoad) begin
        if (bv) begin
          mCnt++;
          if (mCnt == DEPTH) begin mLoad = 0; mRun = 1; mRunCnt = 0; end
        end
      end else if (st) begin
        mLoad = 1; mRun = 0; mDone = 0; mCnt = 0;
      end else if (mRun) begin
        mRunCnt++;
        if (mRunCnt == RUN_CYCLES) begin mRun = 0; mDone = 1; end
      end
      tick();
    end
    clr = 1'b0;
    for (int a = 0; a < DEPTH; a++) chk($sformatf("rnd_mem%0d", a), tbMem[a], modelMem[a]);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
